// File: rtl/smart_parking_pkg.sv
// Shared types and default constants for the multi-slot parking entry controller.
package smart_parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BADPW,
    GRANT,
    STOP,
    REJECT,
    LOCK
  } state_t;

  localparam int             DEF_PASS_W      = 4;
  localparam logic [3:0]     DEF_PASSWORD    = 4'b1011;
  localparam int             DEF_CAPACITY    = 8;
  localparam int             DEF_MAX_TRIES   = 3;
  localparam int             DEF_WAIT_CYCLES = 16;
  localparam int             DEF_LOCK_CYCLES = 64;
  localparam int             DEF_BLINK_DIV   = 4;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A state timed for N cycles loads N-1, since the zero cycle itself still counts.
  function automatic int load_val(input int cycles);
    return (cycles > 1) ? cycles - 1 : 0;
  endfunction

endpackage

// File: rtl/parking_timer.sv
// Loadable saturating down-counter with a zero flag; shared by all timed states.
module parking_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/smart_parking_ctrl.sv
// Car-park entry controller: password-gated entry with retry lockout, tailgate
// detection and occupancy tracking. All panel outputs are registered.
module smart_parking_ctrl
  import smart_parking_pkg::*;
#(
  parameter int                PASS_W      = DEF_PASS_W,
  parameter logic [PASS_W-1:0] PASSWORD    = PASS_W'(DEF_PASSWORD),
  parameter int                CAPACITY    = DEF_CAPACITY,
  parameter int                MAX_TRIES   = DEF_MAX_TRIES,
  parameter int                WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int                LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int                BLINK_DIV   = DEF_BLINK_DIV
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frontsensor,
  input  logic                           backsensor,
  input  logic                           exitsensor,
  input  logic [PASS_W-1:0]              password,
  input  logic                           password_valid,
  output logic                           GREENLED,
  output logic                           REDLED,
  output logic                           gate_open,
  output logic                           full,
  output logic                           lockout,
  output logic [cnt_w(CAPACITY)-1:0]     occupancy
);

  localparam int CNT_W = cnt_w(CAPACITY);
  localparam int TRY_W = cnt_w(MAX_TRIES);
  localparam int TMR_W = cnt_w(max3(WAIT_CYCLES, LOCK_CYCLES, BLINK_DIV));

  localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(load_val(WAIT_CYCLES));
  localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(load_val(LOCK_CYCLES));
  localparam logic [TMR_W-1:0] BLINK_LOAD = TMR_W'(load_val(BLINK_DIV));

  state_t             state_q, state_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               exit_prev_q;
  logic               blink_q, blink_d;
  logic               green_q, green_d;
  logic               red_q, red_d;
  logic               gate_q, gate_d;
  logic               lock_q, lock_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic               pw_match, pw_bad;
  logic               park_done;
  logic               exit_rise, occ_inc, occ_dec;

  parking_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign pw_match = password_valid && (password == PASSWORD);
  assign pw_bad   = password_valid && (password != PASSWORD);
  assign full     = (occ_q == CNT_W'(CAPACITY));

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    blink_d   = blink_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    park_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (frontsensor) begin
          if (full) begin
            state_d = REJECT;
          end else begin
            state_d = WAIT;
            tries_d = '0;
          end
        end
      end
      WAIT, BADPW: begin
        if (pw_match) begin
          state_d = GRANT;
        end else if (pw_bad) begin
          tries_d  = tries_q + TRY_W'(1);
          tmr_load = 1'b1;
          state_d  = ((tries_q + TRY_W'(1)) == TRY_W'(MAX_TRIES)) ? LOCK : BADPW;
        end else if (tmr_zero || !frontsensor) begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (backsensor) begin
          if (frontsensor) begin
            state_d = STOP;
            blink_d = 1'b1;
          end else begin
            state_d   = IDLE;
            park_done = 1'b1;
          end
        end
      end
      STOP: begin
        if (pw_match) begin
          state_d = GRANT;
        end else if (tmr_zero) begin
          blink_d  = !blink_q;
          tmr_load = 1'b1;
        end
      end
      REJECT: begin
        if (!frontsensor || !full) begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (tmr_zero) begin
          state_d = IDLE;
          tries_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry restarts the shared timer with that state's duration.
    if (state_d != state_q) begin
      tmr_load = 1'b1;
    end
    case (state_d)
      WAIT, BADPW: tmr_val = WAIT_LOAD;
      LOCK:        tmr_val = LOCK_LOAD;
      STOP:        tmr_val = BLINK_LOAD;
      default:     tmr_val = '0;
    endcase
  end

  always_comb begin
    green_d = (state_d == GRANT);
    gate_d  = (state_d == GRANT);
    lock_d  = (state_d == LOCK);
    red_d   = (state_d == BADPW) || (state_d == REJECT) || (state_d == LOCK) ||
              ((state_d == STOP) && blink_d);
  end

  // A simultaneous park and exit cancel out; the guards keep the count in range.
  always_comb begin
    exit_rise = exitsensor && !exit_prev_q;
    occ_inc   = park_done && (occ_q != CNT_W'(CAPACITY));
    occ_dec   = exit_rise && (occ_q != '0);
    occ_d     = occ_q;
    if (occ_inc && !occ_dec) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (occ_dec && !occ_inc) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tries_q     <= '0;
      occ_q       <= '0;
      exit_prev_q <= 1'b0;
      blink_q     <= 1'b0;
      green_q     <= 1'b0;
      red_q       <= 1'b0;
      gate_q      <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      occ_q       <= occ_d;
      exit_prev_q <= exitsensor;
      blink_q     <= blink_d;
      green_q     <= green_d;
      red_q       <= red_d;
      gate_q      <= gate_d;
      lock_q      <= lock_d;
    end
  end

  assign GREENLED  = green_q;
  assign REDLED    = red_q;
  assign gate_open = gate_q;
  assign lockout   = lock_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_smart_parking_ctrl.sv
// Scoreboard bench: the driver pushes the reference model's expected panel state
// each cycle, the monitor pops and compares it after every rising edge.
module tb_smart_parking_ctrl;

  localparam int              PASS_W      = 4;
  localparam logic [3:0]      PASSWORD    = 4'b1011;
  localparam int              CAPACITY    = 8;
  localparam int              MAX_TRIES   = 3;
  localparam int              WAIT_CYCLES = 16;
  localparam int              LOCK_CYCLES = 64;
  localparam int              BLINK_DIV   = 4;
  localparam int              CNT_W       = $clog2(CAPACITY + 1);
  localparam logic [3:0]      GOOD        = 4'b1011;
  localparam logic [3:0]      BAD         = 4'b0101;

  // {GREENLED, REDLED, gate_open, full, lockout, occupancy}
  typedef logic [CNT_W+4:0] obs_t;
  typedef enum int {M_IDLE, M_WAIT, M_BADPW, M_GRANT, M_STOP, M_REJECT, M_LOCK} mode_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frontsensor = 1'b0;
  logic              backsensor = 1'b0;
  logic              exitsensor = 1'b0;
  logic [PASS_W-1:0] password = '0;
  logic              password_valid = 1'b0;
  logic              GREENLED, REDLED, gate_open, full, lockout;
  logic [CNT_W-1:0]  occupancy;

  int    checks = 0;
  int    errors = 0;
  obs_t  expQ[$];

  // Reference model: entry times are absolute edge numbers, not counters.
  mode_t mode = M_IDLE;
  int    cyc = 0;
  int    entered = 0;
  int    tries = 0;
  int    cars = 0;
  bit    exitPrev = 1'b0;

  smart_parking_ctrl #(
    .PASS_W      (PASS_W),
    .PASSWORD    (PASSWORD),
    .CAPACITY    (CAPACITY),
    .MAX_TRIES   (MAX_TRIES),
    .WAIT_CYCLES (WAIT_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frontsensor    (frontsensor),
    .backsensor     (backsensor),
    .exitsensor     (exitsensor),
    .password       (password),
    .password_valid (password_valid),
    .GREENLED       (GREENLED),
    .REDLED         (REDLED),
    .gate_open      (gate_open),
    .full           (full),
    .lockout        (lockout),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic obs_t obsNow();
    return {GREENLED, REDLED, gate_open, full, lockout, occupancy};
  endfunction

  function automatic obs_t expectedObs();
    bit red;
    red = (mode == M_BADPW) || (mode == M_REJECT) || (mode == M_LOCK) ||
          ((mode == M_STOP) && ((((cyc - entered) / BLINK_DIV) % 2) == 0));
    return {mode == M_GRANT, red, mode == M_GRANT, cars == CAPACITY, mode == M_LOCK,
            CNT_W'(cars)};
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual G/R/gate/full/lock/occ=%b required=%b",
               name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mode     = M_IDLE;
    cyc      = 0;
    entered  = 0;
    tries    = 0;
    cars     = 0;
    exitPrev = 1'b0;
  endtask

  task automatic modelStep(input bit f, b, e, pv, input logic [PASS_W-1:0] pw);
    int    n;
    bit    match, wrong, parked, leave;
    mode_t nxt;
    n      = cyc + 1;
    match  = pv && (pw == PASSWORD);
    wrong  = pv && (pw != PASSWORD);
    leave  = e && !exitPrev && (cars > 0);
    parked = 1'b0;
    nxt    = mode;
    case (mode)
      M_IDLE: begin
        if (f) begin
          if (cars == CAPACITY) nxt = M_REJECT;
          else begin
            nxt   = M_WAIT;
            tries = 0;
          end
        end
      end
      M_WAIT, M_BADPW: begin
        if (match) nxt = M_GRANT;
        else if (wrong) begin
          tries   = tries + 1;
          nxt     = (tries == MAX_TRIES) ? M_LOCK : M_BADPW;
          entered = n;
        end else if ((n - entered) >= WAIT_CYCLES || !f) nxt = M_IDLE;
      end
      M_GRANT: begin
        if (b && f) nxt = M_STOP;
        else if (b) begin
          nxt    = M_IDLE;
          parked = 1'b1;
        end
      end
      M_STOP:   if (match) nxt = M_GRANT;
      M_REJECT: if (!f || cars != CAPACITY) nxt = M_IDLE;
      M_LOCK: begin
        if ((n - entered) >= LOCK_CYCLES) begin
          nxt   = M_IDLE;
          tries = 0;
        end
      end
      default: nxt = M_IDLE;
    endcase
    if (nxt != mode) entered = n;
    mode     = nxt;
    cars     = cars + ((parked && cars < CAPACITY) ? 1 : 0) - (leave ? 1 : 0);
    exitPrev = e;
    cyc      = n;
  endtask

  task automatic applyStimulus(input bit rstN, f, b, e, pv, input logic [PASS_W-1:0] pw);
    @(negedge clk);
    reset          = rstN;
    frontsensor    = f;
    backsensor     = b;
    exitsensor     = e;
    password_valid = pv;
    password       = pw;
    if (!rstN) modelReset();
    else modelStep(f, b, e, pv, pw);
    expQ.push_back(expectedObs());
  endtask

  task automatic drive(input bit f, b, e, pv, input logic [PASS_W-1:0] pw, input int n);
    repeat (n) applyStimulus(1'b1, f, b, e, pv, pw);
  endtask

  task automatic asyncResetCheck();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset", obsNow(), '0);
    modelReset();
    expQ.push_back(expectedObs());
  endtask

  task automatic randomPhase(input int n);
    bit r, f, b, e, pv;
    logic [PASS_W-1:0] pw;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      f  = ($urandom_range(0, 99) < 60);
      b  = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 3) == 0) e = !e;
      pv = ($urandom_range(0, 99) < 20);
      pw = ($urandom_range(0, 1) == 1) ? GOOD : PASS_W'($urandom_range(0, 15));
      applyStimulus(r, f, b, e, pv, pw);
    end
  endtask

  // Monitor: one expected panel state per rising edge.
  initial begin
    obs_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkOutput("outputs", obsNow(), exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1 checkOutput("reset_state", obsNow(), '0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Correct password, then park one car.
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 1, GOOD, 1);
    drive(1, 0, 0, 0, '0, 3);
    drive(0, 1, 0, 0, '0, 1);
    drive(0, 0, 0, 0, '0, 2);

    // Three wrong passwords into lockout; valid password ignored while locked.
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 1, BAD, 1);
    drive(1, 0, 0, 0, '0, 2);
    drive(1, 0, 0, 1, BAD, 1);
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 1, BAD, 1);
    drive(1, 0, 0, 1, GOOD, 5);
    drive(1, 0, 0, 0, '0, 65);
    drive(0, 0, 0, 0, '0, 3);

    // Tailgate: blink in STOP, wrong password stays, right one re-grants.
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 1, GOOD, 1);
    drive(1, 1, 0, 0, '0, 11);
    drive(1, 1, 0, 1, BAD, 1);
    drive(0, 0, 0, 0, '0, 3);
    drive(0, 0, 0, 1, GOOD, 1);
    drive(0, 1, 0, 0, '0, 1);
    drive(0, 0, 0, 0, '0, 1);

    // Fill to capacity, then reject until a car leaves.
    repeat (6) begin
      drive(1, 0, 0, 0, '0, 1);
      drive(1, 0, 0, 1, GOOD, 1);
      drive(0, 1, 0, 0, '0, 1);
      drive(0, 0, 0, 0, '0, 1);
    end
    drive(1, 0, 0, 1, GOOD, 4);
    drive(1, 0, 1, 0, '0, 1);
    drive(1, 0, 0, 0, '0, 2);
    drive(0, 0, 0, 0, '0, 2);

    // Down to 5, then park and exit on the same edge; drain past zero.
    repeat (2) begin
      drive(0, 0, 1, 0, '0, 1);
      drive(0, 0, 0, 0, '0, 1);
    end
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 1, GOOD, 1);
    drive(0, 1, 1, 0, '0, 1);
    drive(0, 0, 0, 0, '0, 1);
    repeat (7) begin
      drive(0, 0, 1, 0, '0, 1);
      drive(0, 0, 0, 0, '0, 1);
    end

    // Password timeout with the car still waiting.
    drive(1, 0, 0, 0, '0, 20);
    drive(0, 0, 0, 0, '0, 2);

    // Reset asserted mid-cycle while the gate is open.
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 1, GOOD, 1);
    drive(1, 0, 0, 0, '0, 2);
    asyncResetCheck();
    drive(0, 0, 0, 0, '0, 2);

    randomPhase(2000);

    @(posedge clk);
    #3;
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
